// File: rtl/shift_unit_pipe_pkg.sv
// Shared types and constants for the pipelined shift execution unit.
package shift_pkg;

    // Only a 32-bit datapath is supported.
    localparam int SHIFT_N = 32;

    // Shift operation encoding as carried on i_op.
    typedef enum logic [1:0] {
        SHIFT_SLL     = 2'b00,
        SHIFT_SRL     = 2'b01,
        SHIFT_SRA     = 2'b10,
        SHIFT_ILLEGAL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_unit_pipe_shifters.sv
// Combinational log shifters. Each stage is a 2:1 mux per bit that shifts by
// 2**s when shamt[s] is set. The stage outputs live in named generate blocks
// so that every stage is a separate net.

// Logical left shift, zero fill.
module shift_left_logical #(
    parameter int N = 32
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         result
);
    localparam int S = $clog2(N);

    for (genvar s = 0; s < S; s++) begin : g_stage
        logic [N-1:0] in_v;
        logic [N-1:0] out_v;
        if (s == 0) begin : g_first
            assign in_v = data;
        end else begin : g_next
            assign in_v = g_stage[s-1].out_v;
        end
        // Stage s: optionally shift left by 2**s.
        assign out_v = shamt[s] ? {in_v[N-1-(2**s):0], {(2**s){1'b0}}} : in_v;
    end

    assign result = g_stage[S-1].out_v;
endmodule

// Logical right shift, zero fill.
module shift_right_logical #(
    parameter int N = 32
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         result
);
    localparam int S = $clog2(N);

    for (genvar s = 0; s < S; s++) begin : g_stage
        logic [N-1:0] in_v;
        logic [N-1:0] out_v;
        if (s == 0) begin : g_first
            assign in_v = data;
        end else begin : g_next
            assign in_v = g_stage[s-1].out_v;
        end
        // Stage s: optionally shift right by 2**s, filling with zeros.
        assign out_v = shamt[s] ? {{(2**s){1'b0}}, in_v[N-1:2**s]} : in_v;
    end

    assign result = g_stage[S-1].out_v;
endmodule

// Arithmetic right shift. The sign bit is never modified by a stage, so each
// stage can replicate its own input MSB as the fill value.
module shift_right_arithmetic #(
    parameter int N = 32
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         result
);
    localparam int S = $clog2(N);

    for (genvar s = 0; s < S; s++) begin : g_stage
        logic [N-1:0] in_v;
        logic [N-1:0] out_v;
        if (s == 0) begin : g_first
            assign in_v = data;
        end else begin : g_next
            assign in_v = g_stage[s-1].out_v;
        end
        // Stage s: optionally shift right by 2**s, filling with the sign bit.
        assign out_v = shamt[s] ? {{(2**s){in_v[N-1]}}, in_v[N-1:2**s]} : in_v;
    end

    assign result = g_stage[S-1].out_v;
endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift unit: S1 captures the request, the three shifters
// run in parallel between S1 and S2, and S2 holds the result and flags that
// drive the o_* outputs directly. Also keeps a saturating hand-off counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that transfer; ready may
// depend combinationally on the downstream ready (i_ready follows o_ready), and
// o_valid/o_result/o_zero/o_illegal never change while o_valid && !o_ready.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int N     = SHIFT_N,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         i_data,
    input  logic [$clog2(N)-1:0] i_shamt,
    input  logic [1:0]           i_op,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [N-1:0]         o_result,
    output logic                 o_zero,
    output logic                 o_illegal,
    output logic [CNT_W-1:0]     o_count
);

    // Stage 1 registers
    logic                 s1_valid;
    logic [N-1:0]         s1_data;
    logic [$clog2(N)-1:0] s1_shamt;
    shift_op_t            s1_op;

    // Stage 2 registers
    logic                 s2_valid;
    logic [N-1:0]         s2_result;
    logic                 s2_zero;
    logic                 s2_illegal;

    // Advance enables: a stage may load when it is empty or its content leaves.
    logic s1_en;
    logic s2_en;

    assign s2_en   = !s2_valid || o_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign i_ready = s1_en;

    // Parallel shifter results for the S1 operand
    logic [N-1:0] sll_res;
    logic [N-1:0] srl_res;
    logic [N-1:0] sra_res;

    shift_left_logical #(.N(N)) u_sll (
        .data   (s1_data),
        .shamt  (s1_shamt),
        .result (sll_res)
    );

    shift_right_logical #(.N(N)) u_srl (
        .data   (s1_data),
        .shamt  (s1_shamt),
        .result (srl_res)
    );

    shift_right_arithmetic #(.N(N)) u_sra (
        .data   (s1_data),
        .shamt  (s1_shamt),
        .result (sra_res)
    );

    logic [N-1:0] sel_result;
    logic         sel_illegal;
    logic         sel_zero;

    // Pick the shifter output for the S1 op; an illegal op yields zero.
    always_comb begin
        sel_result  = '0;
        sel_illegal = 1'b0;
        case (s1_op)
            SHIFT_SLL: sel_result = sll_res;
            SHIFT_SRL: sel_result = srl_res;
            SHIFT_SRA: sel_result = sra_res;
            default: begin
                sel_result  = '0;
                sel_illegal = 1'b1;
            end
        endcase
        sel_zero = (sel_result == '0);
    end

    // S1: capture the request on accept; valid follows i_valid whenever S1 advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_op    <= SHIFT_SLL;
        end else if (s1_en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_data  <= i_data;
                s1_shamt <= i_shamt;
                s1_op    <= shift_op_t'(i_op);
            end
        end
    end

    // S2: take the selected result when advancing; data only moves with a valid S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= sel_result;
                s2_zero    <= sel_zero;
                s2_illegal <= sel_illegal;
            end
        end
    end

    // Count result hand-offs, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_count <= '0;
        end else if (s2_valid && o_ready && (o_count != {CNT_W{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

    assign o_valid   = s2_valid;
    assign o_result  = s2_result;
    assign o_zero    = s2_zero;
    assign o_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe. A second instance with a 4-bit
// counter shares all inputs and is used for the saturation scenario.
module tb_shift_unit_pipe;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_data;
    logic [4:0]  i_shamt;
    logic [1:0]  i_op;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_illegal;
    logic [15:0] o_count;

    logic        sat_i_ready;
    logic        sat_o_valid;
    logic [31:0] sat_o_result;
    logic        sat_o_zero;
    logic        sat_o_illegal;
    logic [3:0]  sat_o_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Scoreboard entries: {illegal, zero, result}
    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;

    shift_unit_pipe #(.N(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .i_shamt   (i_shamt),
        .i_op      (i_op),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_result  (o_result),
        .o_zero    (o_zero),
        .o_illegal (o_illegal),
        .o_count   (o_count)
    );

    shift_unit_pipe #(.N(32), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (sat_i_ready),
        .i_data    (i_data),
        .i_shamt   (i_shamt),
        .i_op      (i_op),
        .o_valid   (sat_o_valid),
        .o_ready   (o_ready),
        .o_result  (sat_o_result),
        .o_zero    (sat_o_zero),
        .o_illegal (sat_o_illegal),
        .o_count   (sat_o_count)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_shamt = '0;
        i_op    = '0;
        o_ready = 1'b0;
    end

    // Reference model of one request
    function automatic logic [33:0] model(input logic [31:0] d, input logic [4:0] sh,
                                          input logic [1:0] op);
        logic [31:0] r;
        logic        ill;
        ill = 1'b0;
        case (op)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = 32'($signed(d) >>> sh);
            default: begin
                r   = 32'h0;
                ill = 1'b1;
            end
        endcase
        return {ill, (r == 32'h0), r};
    endfunction

    // Scoreboard: pops and compares on hand-off, pushes on accept.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (o_valid && o_ready) begin
                n_checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got result %h, required no result", o_result);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({o_illegal, o_zero, o_result} !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb_result: got ill=%b zero=%b res=%h, required ill=%b zero=%b res=%h",
                                 o_illegal, o_zero, o_result, mon_exp[33], mon_exp[32], mon_exp[31:0]);
                    end
                end
            end
            if (i_valid && i_ready) exp_q.push_back(model(i_data, i_shamt, i_op));
        end
    end

    // Driver: set inputs just after the falling edge, then settle.
    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] op, input logic rdy);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_shamt = sh;
        i_op    = op;
        o_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %b, required 0", o_valid); end
        n_checks++;
        if (o_result !== 32'h0) begin n_fail++; $display("FAIL rst_o_result: got %h, required 0", o_result); end
        n_checks++;
        if (o_zero !== 1'b0) begin n_fail++; $display("FAIL rst_o_zero: got %b, required 0", o_zero); end
        n_checks++;
        if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_o_illegal: got %b, required 0", o_illegal); end
        n_checks++;
        if (o_count !== 16'd0) begin n_fail++; $display("FAIL rst_o_count: got %0d, required 0", o_count); end
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_i_ready: got %b, required 1", i_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] d_tab [4];
        logic [4:0]  s_tab [4];
        logic [1:0]  op_tab [4];
        logic [31:0] r_tab [4];
        logic        z_tab [4];
        d_tab  = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        s_tab  = '{5'd31, 5'd31, 5'd4, 5'd31};
        op_tab = '{2'b00, 2'b01, 2'b10, 2'b10};
        r_tab  = '{32'h8000_0000, 32'h0000_0001, 32'hF800_0000, 32'h0000_0000};
        z_tab  = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, d_tab[k], s_tab[k], op_tab[k], 1'b1);
            n_checks++;
            if (i_ready !== 1'b1) begin n_fail++; $display("FAIL dir_accept[%0d]: got i_ready %b, required 1", k, i_ready); end
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            n_checks++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir_early[%0d]: got o_valid %b, required 0", k, o_valid); end
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            n_checks++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL dir_latency[%0d]: got o_valid %b, required 1", k, o_valid); end
            n_checks++;
            if (o_result !== r_tab[k]) begin n_fail++; $display("FAIL dir_result[%0d]: got %h, required %h", k, o_result, r_tab[k]); end
            n_checks++;
            if (o_zero !== z_tab[k]) begin n_fail++; $display("FAIL dir_zero[%0d]: got %b, required %b", k, o_zero, z_tab[k]); end
        end
        drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
    endtask

    task automatic test_back_to_back();
        int base;
        logic exp_v;
        do_reset();
        base = n_out;
        for (int j = 0; j < 12; j++) begin
            if (j < 8) begin
                drive(1'b1, $urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)), 1'b1);
                n_checks++;
                if (i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: got i_ready %b, required 1", j, i_ready); end
            end else begin
                drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            end
            exp_v = (j >= 2 && j < 10);
            n_checks++;
            if (o_valid !== exp_v) begin n_fail++; $display("FAIL b2b_o_valid[%0d]: got %b, required %b", j, o_valid, exp_v); end
        end
        n_checks++;
        if (o_count !== 16'd8) begin n_fail++; $display("FAIL b2b_count: got %0d, required 8", o_count); end
        n_checks++;
        if (n_out - base != 8) begin n_fail++; $display("FAIL b2b_delivered: got %0d, required 8", n_out - base); end
    endtask

    task automatic test_backpressure();
        logic [31:0] bd [4];
        logic [4:0]  bs [4];
        logic [1:0]  bo [4];
        int          idx;
        int          base;
        logic        have;
        logic [31:0] held;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bd[k] = $urandom();
            bs[k] = 5'($urandom_range(0, 31));
            bo[k] = 2'($urandom_range(0, 2));
        end
        idx  = 0;
        base = n_out;
        have = 1'b0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bd[idx], bs[idx], bo[idx], 1'b0);
            if (o_valid) begin
                if (!have) begin
                    have = 1'b1;
                    held = o_result;
                end else begin
                    n_checks++;
                    if (o_result !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h, required %h", c, o_result, held); end
                end
            end
            if (i_valid && i_ready) idx++;
        end
        n_checks++;
        if (idx != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 2", idx); end
        n_checks++;
        if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_i_ready: got %b, required 0", i_ready); end
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_o_valid: got %b, required 1", o_valid); end
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) drive(1'b1, bd[idx], bs[idx], bo[idx], 1'b1);
            else drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            if (i_valid && i_ready) idx++;
        end
        n_checks++;
        if (idx != 4) begin n_fail++; $display("FAIL bp_all_accepted: got %0d, required 4", idx); end
        n_checks++;
        if (n_out - base != 4) begin n_fail++; $display("FAIL bp_delivered: got %0d, required 4", n_out - base); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_illegal();
        int waited;
        do_reset();
        drive(1'b1, 32'hDEAD_BEEF, 5'd5, 2'b11, 1'b1);
        waited = 0;
        do begin
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            waited++;
        end while (!o_valid && waited < 10);
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ill_timeout: got o_valid %b, required 1", o_valid); end
        n_checks++;
        if (o_result !== 32'h0) begin n_fail++; $display("FAIL ill_result: got %h, required 0", o_result); end
        n_checks++;
        if (o_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b, required 1", o_illegal); end
        n_checks++;
        if (o_zero !== 1'b1) begin n_fail++; $display("FAIL ill_zero: got %b, required 1", o_zero); end
        drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        n_checks++;
        if (o_count !== 16'd1) begin n_fail++; $display("FAIL ill_count: got %0d, required 1", o_count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(1'b1, 32'h0000_1234, 5'd1, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        n_checks++;
        if (o_count !== 16'd1) begin n_fail++; $display("FAIL mid_pre_count: got %0d, required 1", o_count); end
        drive(1'b1, 32'hAAAA_5555, 5'd3, 2'b01, 1'b0);
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept0: got i_ready %b, required 1", i_ready); end
        drive(1'b1, 32'h5555_AAAA, 5'd7, 2'b10, 1'b0);
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept1: got i_ready %b, required 1", i_ready); end
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst     = 1'b0;
        o_ready = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_o_valid: got %b, required 0", o_valid); end
        n_checks++;
        if (o_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d, required 0", o_count); end
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_i_ready: got %b, required 1", i_ready); end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            n_checks++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got o_valid %b, required 0", c, o_valid); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int j = 0; j < 24; j++) begin
            if (j < 20) drive(1'b1, $urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
            else drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        end
        n_checks++;
        if (sat_o_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d, required 15", sat_o_count); end
        n_checks++;
        if (o_count !== 16'd20) begin n_fail++; $display("FAIL sat_wide_count: got %0d, required 20", o_count); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
